// File: rtl/counter_bcd2bin_unit.sv
// -----------------------------------------------------------------------------
// counter_bcd2bin_unit
//   Count-and-convert stage. A gated 6-bit binary up-counter feeds an
//   SN74184-style BCD-to-binary converter, so that every 6-bit code is
//   presented to the converter in turn.
//
// Ports
//   i_clk            system clock, rising-edge active
//   i_ctr_clear_n    asynchronous active-low clear of the counter
//   i_enable         global clock enable (run control); 0 freezes the counter
//   i_ctr_enable     counter enable, active-high
//   i_conv_enable_n  converter enable, active-low
//   o_counter_out    current counter value
//   o_out184         binary value of o_counter_out read as BCD
//                    (all ones for non-BCD codes or when the converter is off)
// -----------------------------------------------------------------------------
module counter_bcd2bin_unit #(
  parameter int WIDTH = 6
) (
  input  logic             i_clk,
  input  logic             i_ctr_clear_n,
  input  logic             i_enable,
  input  logic             i_ctr_enable,
  input  logic             i_conv_enable_n,
  output logic [WIDTH-1:0] o_counter_out,
  output logic [WIDTH-1:0] o_out184
);

  // Two BCD digits packed in six bits: tens in [5:4] (0..3), units in [3:0].
  // A disabled converter or an out-of-range units digit gives all ones,
  // matching the open-collector outputs of the original part floating high.
  // Bit 0 of the sum always equals code[0] because tens*10 is even.
  function automatic logic [5:0] bcd184(input logic [5:0] code,
                                        input logic       dis_n);
    logic [1:0] tens;
    logic [3:0] units;
    logic [5:0] result;
    tens  = code[5:4];
    units = code[3:0];
    if (dis_n) begin
      result = 6'h3F;
    end else if (units > 4'd9) begin
      result = 6'h3F;
    end else begin
      result = ({4'd0, tens} * 6'd10) + {2'd0, units};
    end
    return result;
  endfunction

  logic [5:0] r_count;
  logic [5:0] w_out184;

  // Binary up-counter: async clear, increments only when both enables are high.
  always_ff @(posedge i_clk or negedge i_ctr_clear_n) begin
    if (!i_ctr_clear_n) begin
      r_count <= 6'd0;
    end else if (i_enable && i_ctr_enable) begin
      r_count <= r_count + 6'd1;
    end else begin
      r_count <= r_count;
    end
  end

  // Combinational BCD-to-binary decode of the live counter value.
  always_comb begin
    w_out184 = 6'h3F;
    w_out184 = bcd184(r_count, i_conv_enable_n);
  end

  assign o_counter_out = r_count;
  assign o_out184      = w_out184;

endmodule

// File: tb/tb_counter_bcd2bin_unit.sv
module tb_counter_bcd2bin_unit;

  logic       clk;
  logic       ctr_clear_n;
  logic       enable;
  logic       ctr_enable;
  logic       conv_enable_n;
  logic [5:0] counter_out;
  logic [5:0] out184;

  typedef struct packed {
    logic [5:0] cnt;
    logic [5:0] conv;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       e;
  logic [5:0] m_cnt;
  int         checks;
  int         failures;

  counter_bcd2bin_unit #(.WIDTH(6)) dut (
    .i_clk           (clk),
    .i_ctr_clear_n   (ctr_clear_n),
    .i_enable        (enable),
    .i_ctr_enable    (ctr_enable),
    .i_conv_enable_n (conv_enable_n),
    .o_counter_out   (counter_out),
    .o_out184        (out184)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode straight from the BCD definition.
  function automatic logic [5:0] ref184(input logic [5:0] c, input logic dis_n);
    int t;
    int u;
    t = int'(c[5:4]);
    u = int'(c[3:0]);
    if (dis_n) return 6'h3F;
    if (u > 9) return 6'h3F;
    return 6'(t * 10 + u);
  endfunction

  // Push expectation for the present model state.
  task automatic push_exp();
    sb_q.push_back({m_cnt, ref184(m_cnt, conv_enable_n)});
  endtask

  // One clock edge: advance the model, sample 1 time unit later, push expectation.
  task automatic step();
    @(posedge clk);
    if (!ctr_clear_n) m_cnt = 6'd0;
    else if (enable && ctr_enable) m_cnt = m_cnt + 6'd1;
    #1;
    push_exp();
  endtask

  task automatic test_reset();
    ctr_clear_n   = 1'b0;
    enable        = 1'b0;
    ctr_enable    = 1'b0;
    conv_enable_n = 1'b1;
    m_cnt         = 6'd0;
    #2;
    push_exp();
    e = sb_q.pop_front();
    checks++;
    if (counter_out !== e.cnt) begin
      failures++;
      $display("FAIL reset_count got=%h exp=%h", counter_out, e.cnt);
    end
    checks++;
    if (out184 !== 6'h3F) begin
      failures++;
      $display("FAIL reset_conv_off got=%h exp=3f", out184);
    end
    conv_enable_n = 1'b0;
    #1;
    checks++;
    if (out184 !== 6'd0) begin
      failures++;
      $display("FAIL reset_conv_on got=%h exp=00", out184);
    end
  endtask

  task automatic test_count();
    @(negedge clk);
    ctr_clear_n = 1'b1;
    enable      = 1'b1;
    ctr_enable  = 1'b1;
    for (int i = 0; i < 23; i++) begin
      step();
      e = sb_q.pop_front();
      checks++;
      if (counter_out !== e.cnt || out184 !== e.conv) begin
        failures++;
        $display("FAIL count_step cnt=%h/%h conv=%h/%h", counter_out, e.cnt, out184, e.conv);
      end
      if (m_cnt == 6'h09) begin
        checks++;
        if (out184 !== 6'd9) begin
          failures++;
          $display("FAIL decode_09 got=%0d exp=9", out184);
        end
      end
      if (m_cnt == 6'h0A) begin
        checks++;
        if (out184 !== 6'h3F) begin
          failures++;
          $display("FAIL invalid_0A got=%h exp=3f", out184);
        end
      end
    end
    checks++;
    if (counter_out !== 6'h17 || out184 !== 6'd17) begin
      failures++;
      $display("FAIL count_23 cnt=%h exp=17 conv=%0d exp=17", counter_out, out184);
    end
  endtask

  task automatic test_decode();
    while (m_cnt != 6'h39) begin
      step();
      e = sb_q.pop_front();
      checks++;
      if (counter_out !== e.cnt || out184 !== e.conv) begin
        failures++;
        $display("FAIL decode_step cnt=%h/%h conv=%h/%h", counter_out, e.cnt, out184, e.conv);
      end
      if (m_cnt[3:0] <= 4'd9) begin
        checks++;
        if (out184[0] !== m_cnt[0]) begin
          failures++;
          $display("FAIL bit0_pass cnt=%h got=%b exp=%b", m_cnt, out184[0], m_cnt[0]);
        end
      end
      if (m_cnt == 6'h25) begin
        checks++;
        if (out184 !== 6'd25) begin
          failures++;
          $display("FAIL decode_25 got=%0d exp=25", out184);
        end
      end
      if (m_cnt == 6'h2F) begin
        checks++;
        if (out184 !== 6'h3F) begin
          failures++;
          $display("FAIL invalid_2F got=%h exp=3f", out184);
        end
      end
    end
    checks++;
    if (out184 !== 6'b100111) begin
      failures++;
      $display("FAIL decode_39 got=%0d exp=39", out184);
    end
  endtask

  task automatic test_hold();
    ctr_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) conv_enable_n = 1'b1;
      if (i == 4) conv_enable_n = 1'b0;
      step();
      e = sb_q.pop_front();
      checks++;
      if (counter_out !== 6'h39 || out184 !== e.conv) begin
        failures++;
        $display("FAIL hold_ctr_en cnt=%h exp=39 conv=%h/%h", counter_out, out184, e.conv);
      end
    end
    ctr_enable = 1'b1;
    enable     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      e = sb_q.pop_front();
      checks++;
      if (counter_out !== 6'h39 || out184 !== e.conv) begin
        failures++;
        $display("FAIL hold_enable cnt=%h exp=39 conv=%h/%h", counter_out, out184, e.conv);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_wrap();
    while (m_cnt != 6'h3F) begin
      step();
      e = sb_q.pop_front();
      checks++;
      if (counter_out !== e.cnt || out184 !== e.conv) begin
        failures++;
        $display("FAIL wrap_step cnt=%h/%h conv=%h/%h", counter_out, e.cnt, out184, e.conv);
      end
    end
    step();
    e = sb_q.pop_front();
    checks++;
    if (counter_out !== 6'd0 || out184 !== 6'd0 || e.cnt !== 6'd0) begin
      failures++;
      $display("FAIL wrap_63_0 cnt=%h exp=00 conv=%h exp=00", counter_out, out184);
    end
  endtask

  task automatic test_async_reset();
    while (m_cnt != 6'h30) begin
      step();
      e = sb_q.pop_front();
      checks++;
      if (counter_out !== e.cnt || out184 !== e.conv) begin
        failures++;
        $display("FAIL run_step cnt=%h/%h conv=%h/%h", counter_out, e.cnt, out184, e.conv);
      end
    end
    checks++;
    if (out184 !== 6'd30) begin
      failures++;
      $display("FAIL decode_30 got=%0d exp=30", out184);
    end
    #2;
    ctr_clear_n = 1'b0;
    m_cnt       = 6'd0;
    #1;
    push_exp();
    e = sb_q.pop_front();
    checks++;
    if (counter_out !== e.cnt || out184 !== e.conv) begin
      failures++;
      $display("FAIL async_clear cnt=%h/%h conv=%h/%h", counter_out, e.cnt, out184, e.conv);
    end
    #1;
    ctr_clear_n = 1'b1;
    step();
    e = sb_q.pop_front();
    checks++;
    if (counter_out !== 6'd1 || out184 !== 6'd1) begin
      failures++;
      $display("FAIL restart_1 cnt=%h exp=01 conv=%h exp=01", counter_out, out184);
    end
  endtask

  task automatic test_reset_wins();
    ctr_clear_n = 1'b0;
    step();
    e = sb_q.pop_front();
    checks++;
    if (counter_out !== 6'd0 || e.cnt !== 6'd0) begin
      failures++;
      $display("FAIL reset_wins cnt=%h exp=00", counter_out);
    end
    #2;
    ctr_clear_n = 1'b1;
    step();
    e = sb_q.pop_front();
    checks++;
    if (counter_out !== e.cnt || counter_out !== 6'd1) begin
      failures++;
      $display("FAIL after_reset cnt=%h exp=01", counter_out);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_count();
    test_decode();
    test_hold();
    test_wrap();
    test_async_reset();
    test_reset_wins();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_bcd2bin_unit.md
Name: counter_bcd2bin_unit

Overview:
Self-contained count-and-convert stage: a clock-enable gate, a 6-bit binary up-counter, and an SN74184-style BCD-to-binary converter that decodes the counter value. It exercises the converter over every 6-bit input code.
- Counter output drives the converter directly.
- Both counter value and converted value are brought out for checking.
- Sits beside the binary-to-BCD (185-style) path, which is outside this block.

Parameters:
- WIDTH, 6, counter and converter data width. Fixed at 6; other values unsupported.

Ports:
- clk  input  1  system clock, rising-edge active
- ctr_clear_n  input  1  asynchronous, active-low reset/clear of the counter
- enable  input  1  global clock enable (models the clock generator run control); 0 freezes the counter
- ctr_enable  input  1  counter enable, active-high
- conv_enable_n  input  1  converter enable, active-low
- counter_out  output  6  current counter value
- out184  output  6  converted binary value of counter_out interpreted as BCD

Behaviour:
Reset
- ctr_clear_n = 0 immediately forces counter_out = 6'd0, independent of clk.
- While reset is held, out184 follows its combinational rule for input 0: 6'd0 if conv_enable_n = 0, else 6'h3F.
- Counting resumes on the first rising clk edge after ctr_clear_n returns to 1 with both enables high.

Counter
- Rising clk edge with enable = 1 and ctr_enable = 1: counter_out <= counter_out + 1, modulo 64.
- Wraps 6'd63 -> 6'd0, with no carry or flag output.
- Either enable low: counter_out holds its value.
- Reset asserted on the same edge as an increment: reset wins.
- The counter is plain binary, not BCD; it passes through non-BCD codes.

Converter (combinational, zero latency from counter_out)
- Input split: tens = counter_out[5:4] (0..3), units = counter_out[3:0].
- Valid BCD (units <= 9): out184 = tens*10 + units, range 0..39.
- Bit 0 passes straight through: out184[0] = counter_out[0].
- Invalid BCD (units 10..15): out184 = 6'h3F.
- conv_enable_n = 1: out184 = 6'h3F (disabled, open-collector-high equivalent), overriding the rules above.
- Fully combinational; no clock or reset dependency beyond counter_out.
- Use an explicit sum (tens*10 + units) or a 64-entry case table; results must be identical.

Boundary cases
- counter_out = 6'h39 -> 39; 6'h3A..6'h3F -> 6'h3F.
- Toggling conv_enable_n mid-count does not disturb the counter.
- Async reset mid-count: counter_out is 0 within the same delta/cycle, and out184 updates combinationally.

Test Plan:
- Reset / disabled conv: ctr_clear_n = 0, conv_enable_n = 1 -> counter_out = 0, out184 = 6'h3F. Then conv_enable_n = 0 -> out184 = 0.
- Count run: release reset, enable = ctr_enable = 1, 23 rising edges -> counter_out = 6'h17, out184 = 17 (6'b010001).
- Valid decode points:
  - counter_out = 6'h25 -> out184 = 25.
  - counter_out = 6'h39 -> out184 = 39 (6'b100111).
  - counter_out = 6'h09 -> out184 = 9.
- Invalid BCD: counter_out = 6'h0A and 6'h2F -> out184 = 6'h3F; bit-0 passthrough is checked on all valid codes.
- Hold and wrap:
  - ctr_enable = 0 for 5 cycles, then enable = 0 for 5 cycles -> counter_out unchanged in both.
  - From 63, one enabled edge -> counter_out = 0, out184 = 0.
- Async reset mid-run: at counter_out = 6'h30, pulse ctr_clear_n low between edges -> counter_out = 0 immediately; counting restarts at 1 on the next enabled edge.
